// File: rtl/mc_ctrl.sv
// Multicycle processor control unit: sequences fetch, decode, memory access,
// ALU execute and write-back for a six-opcode instruction set.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  // state   | meaning
  // FETCH   | read instruction at PC, load IR and PC+4 on mem_ready
  // DECODE  | read registers, precompute branch target, dispatch on op
  // MEMADR  | compute load/store effective address
  // MEMRD   | load data read, waits for mem_ready
  // MEMWB   | write loaded data to register file
  // MEMWR   | store write, strobe held until mem_ready
  // RTYPEEX | ALU operation selected by funct
  // ALUWB   | write ALU result to rd
  // BEQEX   | compare and conditionally load branch target
  // ADDIEX  | add sign-extended immediate
  // ADDIWB  | write immediate result to rt
  // JEX     | load jump target into PC

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:   if (mem_ready) st <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: st <= S_MEMADR;
            OP_RTYPE:     st <= S_RTYPEEX;
            OP_BEQ:       st <= S_BEQEX;
            OP_ADDI:      st <= S_ADDIEX;
            OP_J:         st <= S_JEX;
            default:      st <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          // op is held in IR, so it cannot change here; anything else is recovered via FETCH
          if (op == OP_LW)      st <= S_MEMRD;
          else if (op == OP_SW) st <= S_MEMWR;
          else                  st <= S_FETCH;
        end
        S_MEMRD:   if (mem_ready) st <= S_MEMWB;
        S_MEMWB:   st <= S_FETCH;
        S_MEMWR:   if (mem_ready) st <= S_FETCH;
        S_RTYPEEX: st <= S_ALUWB;
        S_ALUWB:   st <= S_FETCH;
        S_BEQEX:   st <= S_FETCH;
        S_ADDIEX:  st <= S_ADDIWB;
        S_ADDIWB:  st <= S_FETCH;
        S_JEX:     st <= S_FETCH;
        default:   st <= S_FETCH;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (st)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal_op = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                       op == OP_BEQ || op == OP_ADDI || op == OP_J);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed per-cycle vector table for mc_ctrl plus hand sequences for reset
// during a store wait and a load with memory wait states.
module tb_mc_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // {iord,memread,memwrite,irwrite,pcwrite,branch,regdst,regwrite,memtoreg,alusrca,
  //  alusrcb[2],pcsrc[2],aluop[2],instr_done,illegal_op}
  localparam logic [17:0] F_WAIT   = 18'b0_1_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] F_RDY    = 18'b0_1_0_1_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] DEC      = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] MEMADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] MEMRD    = 18'b1_1_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] MEMWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] MWR_WAIT = 18'b1_0_1_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] MWR_RDY  = 18'b1_0_1_0_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] RTYPEEX  = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [17:0] ALUWB    = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] BEQEX    = 18'b0_0_0_0_0_1_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] ADDIEX   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] ADDIWB   = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] JEX      = 18'b0_0_0_0_1_0_0_0_0_0_00_10_00_1_0;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       iord, memread, memwrite, irwrite, pcwrite, branch;
  logic       regdst, regwrite, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;
  logic       instr_done, illegal_op;
  logic [17:0] ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .regdst(regdst), .regwrite(regwrite),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  assign ctl = {iord, memread, memwrite, irwrite, pcwrite, branch, regdst, regwrite,
                memtoreg, alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op};

  typedef struct {
    logic        rst;
    logic        mr;
    logic [5:0]  op;
    logic        chk;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  localparam int NV = 39;
  vec_t tv[NV];

  function automatic vec_t mk(input logic r, input logic m, input logic [5:0] o,
                              input logic c, input logic [3:0] s, input logic [17:0] x);
    vec_t v;
    v.rst = r; v.mr = m; v.op = o; v.chk = c; v.st = s; v.ctl = x;
    return v;
  endfunction

  // Drive inputs just after the rising edge, then sample at the falling edge.
  task automatic step(input logic r, input logic m, input logic [5:0] o);
    @(posedge clk);
    #1;
    rst = r; mem_ready = m; op = o;
    @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [3:0] want);
    checks++;
    if (state !== want) begin
      failures++;
      $display("FAIL %s state: got %0d want %0d", name, state, want);
    end
  endtask

  task automatic check_ctl(input string name, input logic [17:0] want);
    checks++;
    if (ctl !== want) begin
      failures++;
      $display("FAIL %s outputs: got %b want %b", name, ctl, want);
    end
  endtask

  initial begin
    // reset held, then LW with no waits
    tv[0]  = mk(1, 0, OP_RTYPE, 1, 0,  F_WAIT);
    tv[1]  = mk(1, 1, OP_RTYPE, 1, 0,  F_RDY);
    tv[2]  = mk(0, 1, OP_LW,    1, 0,  F_RDY);
    tv[3]  = mk(0, 1, OP_LW,    1, 1,  DEC);
    tv[4]  = mk(0, 1, OP_LW,    1, 2,  MEMADR);
    tv[5]  = mk(0, 1, OP_LW,    1, 3,  MEMRD);
    tv[6]  = mk(0, 1, OP_LW,    1, 4,  MEMWB);
    // SW with three wait cycles in MEMWR
    tv[7]  = mk(0, 1, OP_SW,    1, 0,  F_RDY);
    tv[8]  = mk(0, 1, OP_SW,    1, 1,  DEC);
    tv[9]  = mk(0, 1, OP_SW,    1, 2,  MEMADR);
    tv[10] = mk(0, 0, OP_SW,    1, 5,  MWR_WAIT);
    tv[11] = mk(0, 0, OP_SW,    1, 5,  MWR_WAIT);
    tv[12] = mk(0, 0, OP_SW,    1, 5,  MWR_WAIT);
    tv[13] = mk(0, 1, OP_SW,    1, 5,  MWR_RDY);
    // BEQ
    tv[14] = mk(0, 1, OP_BEQ,   1, 0,  F_RDY);
    tv[15] = mk(0, 1, OP_BEQ,   1, 1,  DEC);
    tv[16] = mk(0, 1, OP_BEQ,   1, 8,  BEQEX);
    // illegal opcode
    tv[17] = mk(0, 1, OP_BAD,   1, 0,  F_RDY);
    tv[18] = mk(0, 1, OP_BAD,   1, 1,  DEC_ILL);
    // ADDI after two fetch wait cycles
    tv[19] = mk(0, 0, OP_ADDI,  1, 0,  F_WAIT);
    tv[20] = mk(0, 0, OP_ADDI,  1, 0,  F_WAIT);
    tv[21] = mk(0, 1, OP_ADDI,  1, 0,  F_RDY);
    tv[22] = mk(0, 1, OP_ADDI,  1, 1,  DEC);
    tv[23] = mk(0, 1, OP_ADDI,  1, 9,  ADDIEX);
    tv[24] = mk(0, 1, OP_ADDI,  1, 10, ADDIWB);
    // J, mem_ready low where it must be ignored
    tv[25] = mk(0, 1, OP_J,     1, 0,  F_RDY);
    tv[26] = mk(0, 0, OP_J,     1, 1,  DEC);
    tv[27] = mk(0, 0, OP_J,     1, 11, JEX);
    // reset while waiting in MEMRD, then R_TYPE
    tv[28] = mk(0, 1, OP_LW,    1, 0,  F_RDY);
    tv[29] = mk(0, 1, OP_LW,    1, 1,  DEC);
    tv[30] = mk(0, 1, OP_LW,    1, 2,  MEMADR);
    tv[31] = mk(0, 0, OP_LW,    1, 3,  MEMRD);
    tv[32] = mk(1, 0, OP_LW,    0, 3,  MEMRD);
    tv[33] = mk(1, 1, OP_RTYPE, 1, 0,  F_RDY);
    tv[34] = mk(0, 1, OP_RTYPE, 1, 0,  F_RDY);
    tv[35] = mk(0, 1, OP_RTYPE, 1, 1,  DEC);
    tv[36] = mk(0, 1, OP_RTYPE, 1, 6,  RTYPEEX);
    tv[37] = mk(0, 1, OP_RTYPE, 1, 7,  ALUWB);
    tv[38] = mk(0, 1, OP_RTYPE, 1, 0,  F_RDY);

    rst = 1'b1; mem_ready = 1'b0; op = OP_RTYPE;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      step(tv[i].rst, tv[i].mr, tv[i].op);
      if (tv[i].chk) begin
        check_state($sformatf("row%0d", i), tv[i].st);
        check_ctl($sformatf("row%0d", i), tv[i].ctl);
      end
    end

    // Reset mid-wait in MEMWR: store strobe must drop on the cycle after the reset edge.
    step(0, 1, OP_SW);
    check_state("sw_rst_dec", 1);
    step(0, 1, OP_SW);
    check_state("sw_rst_adr", 2);
    step(0, 0, OP_SW);
    check_ctl("sw_rst_wr", MWR_WAIT);
    step(1, 0, OP_SW);
    step(0, 0, OP_SW);
    check_state("sw_rst_after", 0);
    check_ctl("sw_rst_after", F_WAIT);

    // LW with four wait cycles in MEMRD: instr_done expected on cycle index 8 (9 cycles total).
    begin
      int done_at;
      int pulses;
      done_at = -1;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
        step(0, (c >= 3 && c <= 6) ? 1'b0 : 1'b1, OP_LW);
        if (instr_done) begin
          pulses++;
          if (done_at < 0) done_at = c;
        end
        if (c == 8) begin
          check_ctl("lw_wait_wb", MEMWB);
        end
        if (c == 9) begin
          check_state("lw_wait_ret", 0);
          break;
        end
      end
      checks++;
      if (done_at != 8) begin
        failures++;
        if (done_at < 0) $display("FAIL lw_wait_latency: timeout, no instr_done within 30 cycles");
        else $display("FAIL lw_wait_latency: got cycle %0d want cycle 8", done_at);
      end
      checks++;
      if (pulses != 1) begin
        failures++;
        $display("FAIL lw_wait_pulses: got %0d want 1", pulses);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
